// File: rtl/rl_pkg.sv
// rl_pkg: shared widths, FSM encoding and helpers for the greedy action
// selection controller.
// No ports. Provides DATA_W/ADDR_W/N_ACT, state/action field widths,
// the FSM state enum, the signed Q-value type and the RAM address builder.
package rl_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;
  localparam int N_ACT   = 4;
  localparam int STATE_W = 4;
  localparam int ACT_W   = 2;

  typedef logic signed [DATA_W-1:0] qval_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

  // Action RAM address is {state, action}.
  function automatic logic [ADDR_W-1:0] make_addr(input logic [STATE_W-1:0] st,
                                                  input logic [ACT_W-1:0]   act);
    return {st, act};
  endfunction

endpackage

// File: rtl/action_select_ctrl_if.sv
// action_select_ctrl_if: bundles the select handshake, the Q-update write
// port and the action RAM port of the controller.
// master: requester side (drives sel_req/sel_state and upd_*).
// slave : controller side (answers the handshakes, drives the RAM port,
//         consumes ram_data_out).
interface action_select_ctrl_if;
  import rl_pkg::*;

  logic                 sel_req;
  logic [STATE_W-1:0]   sel_state;
  logic                 sel_ready;
  logic                 sel_done;
  logic [ACT_W-1:0]     sel_action;
  qval_t                sel_value;

  logic                 upd_valid;
  logic [ADDR_W-1:0]    upd_addr;
  qval_t                upd_data;
  logic                 upd_ready;

  logic                 ram_en;
  logic                 ram_write_en;
  logic [ADDR_W-1:0]    ram_wr_addr;
  logic [ADDR_W-1:0]    ram_rd_addr;
  qval_t                ram_data_in;
  qval_t                ram_data_out;

  modport master (
    output sel_req, sel_state, upd_valid, upd_addr, upd_data,
    input  sel_ready, sel_done, sel_action, sel_value, upd_ready
  );

  modport slave (
    input  sel_req, sel_state, upd_valid, upd_addr, upd_data, ram_data_out,
    output sel_ready, sel_done, sel_action, sel_value, upd_ready,
           ram_en, ram_write_en, ram_wr_addr, ram_rd_addr, ram_data_in
  );
endinterface

// File: rtl/action_argmax.sv
// action_argmax: running signed argmax over a stream of (value, index).
// Ports: clk, rst (sync, active-high); cmp_en_i qualifies a candidate,
// first_i forces an unconditional load, cand_val_i/cand_idx_i the candidate;
// best_val_nxt_o/best_idx_nxt_o give the best including this cycle's candidate.
module action_argmax
  import rl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_en_i,
  input  logic             first_i,
  input  qval_t            cand_val_i,
  input  logic [ACT_W-1:0] cand_idx_i,
  output qval_t            best_val_nxt_o,
  output logic [ACT_W-1:0] best_idx_nxt_o
);

  qval_t            best_val_q, best_val_d;
  logic [ACT_W-1:0] best_idx_q, best_idx_d;

  // Strictly-greater replace keeps the lowest index on ties.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (cmp_en_i && (first_i || (cand_val_i > best_val_q))) begin
      best_val_d = cand_val_i;
      best_idx_d = cand_idx_i;
    end else begin
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
    end
  end

  // Best value/index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_val_nxt_o = best_val_d;
  assign best_idx_nxt_o = best_idx_d;

endmodule

// File: rtl/action_select_ctrl.sv
// action_select_ctrl: finds the greedy (argmax) action of a state by reading
// its N_ACT action values from an external synchronous RAM, while letting
// Q-update writes through unless they target the state being scanned.
// Ports: clk, rst (sync, active-high), bus (slave modport: select handshake,
// update write port, action RAM port).
module action_select_ctrl
  import rl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  action_select_ctrl_if.slave   bus
);

  fsm_state_e        state_q, state_d;
  logic [ACT_W-1:0]  k_q, k_d;
  logic [STATE_W-1:0] lat_q, lat_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [ACT_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [ACT_W-1:0]  act_q, act_d;
  qval_t             val_q, val_d;

  logic              wr_blocked_s, wr_go_s, sel_ready_s, sel_go_s;
  logic [ACT_W-1:0]  best_idx_nxt_s;
  qval_t             best_val_nxt_s;

  // Handshake arbitration: a write in IDLE takes priority over a search.
  always_comb begin
    wr_blocked_s = (state_q != ST_IDLE) && (bus.upd_addr[ADDR_W-1:ACT_W] == lat_q);
    wr_go_s      = !rst && bus.upd_valid && !wr_blocked_s;
    sel_ready_s  = !rst && (state_q == ST_IDLE) && !wr_go_s;
    sel_go_s     = sel_ready_s && bus.sel_req;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_go_s) state_d = ST_SCAN;
        else          state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (k_q == ACT_W'(N_ACT - 1)) state_d = ST_DRAIN;
        else                          state_d = ST_SCAN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: scan counter, latched state, read-return tracking
  // (RAM data lags the address by one cycle) and the result registers.
  always_comb begin
    k_d       = (state_q == ST_SCAN) ? (k_q + 2'd1) : 2'd0;
    lat_d     = sel_go_s ? bus.sel_state : lat_q;
    cmp_vld_d = (state_q == ST_SCAN);
    cmp_idx_d = k_q;
    if (state_q == ST_DRAIN) begin
      // Final compare happens this cycle, so take the argmax's next value.
      act_d = best_idx_nxt_s;
      val_d = best_val_nxt_s;
    end else begin
      act_d = act_q;
      val_d = val_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      lat_q     <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      act_q     <= '0;
      val_q     <= '0;
    end else begin
      k_q       <= k_d;
      lat_q     <= lat_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      act_q     <= act_d;
      val_q     <= val_d;
    end
  end

  action_argmax u_argmax (
    .clk            (clk),
    .rst            (rst),
    .cmp_en_i       (cmp_vld_q),
    .first_i        (cmp_idx_q == 2'd0),
    .cand_val_i     (bus.ram_data_out),
    .cand_idx_i     (cmp_idx_q),
    .best_val_nxt_o (best_val_nxt_s),
    .best_idx_nxt_o (best_idx_nxt_s)
  );

  // FSM / port outputs.
  always_comb begin
    bus.sel_ready    = sel_ready_s;
    bus.sel_done     = !rst && (state_q == ST_DONE);
    bus.sel_action   = act_q;
    bus.sel_value    = val_q;
    bus.upd_ready    = wr_go_s;
    bus.ram_en       = !rst;
    bus.ram_write_en = wr_go_s;
    if (wr_go_s) begin
      bus.ram_wr_addr = bus.upd_addr;
      bus.ram_data_in = bus.upd_data;
    end else begin
      bus.ram_wr_addr = '0;
      bus.ram_data_in = '0;
    end
    if (!rst && (state_q == ST_SCAN)) bus.ram_rd_addr = make_addr(lat_q, k_q);
    else                              bus.ram_rd_addr = '0;
  end

endmodule

// File: tb/tb_action_select_ctrl.sv
// tb_action_select_ctrl: directed test of action_select_ctrl with a
// behavioural synchronous action RAM and hand-computed expected results.
module tb_action_select_ctrl;
  import rl_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  qval_t mem [0:(1<<ADDR_W)-1];

  action_select_ctrl_if bus ();

  action_select_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_write_en) mem[bus.ram_wr_addr] <= bus.ram_data_in;
      bus.ram_data_out <= mem[bus.ram_rd_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input int d);
    @(negedge clk);
    bus.upd_valid = 1'b1;
    bus.upd_addr  = a;
    bus.upd_data  = qval_t'(d);
    #1 chk("upd_ready", bus.upd_ready, 1);
    @(negedge clk);
    bus.upd_valid = 1'b0;
  endtask

  // Issues a request; returns at the negedge of cycle T+1.
  task automatic start_sel(input logic [STATE_W-1:0] s);
    @(negedge clk);
    bus.sel_req   = 1'b1;
    bus.sel_state = s;
    #1 chk("sel_ready", bus.sel_ready, 1);
    @(negedge clk);
    bus.sel_req = 1'b0;
  endtask

  // Waits for sel_done starting at cycle T+cyc0; checks latency and result.
  task automatic wait_done(input int cyc0, input int exp_act, input int exp_val);
    int cyc;
    cyc = cyc0;
    while (!bus.sel_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("sel_done_seen", bus.sel_done, 1);
    chk("latency", cyc, 6);
    chk("sel_action", bus.sel_action, exp_act);
    chk("sel_value", bus.sel_value, exp_val);
    @(negedge clk);
    chk("done_pulse", bus.sel_done, 0);
    chk("value_hold", bus.sel_value, exp_val);
  endtask

  initial begin
    int seen;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    rst = 1'b1;
    bus.sel_req = 1'b0; bus.sel_state = '0;
    bus.upd_valid = 1'b0; bus.upd_addr = '0; bus.upd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_sel_done", bus.sel_done, 0);
    chk("rst_sel_action", bus.sel_action, 0);
    chk("rst_sel_value", bus.sel_value, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_ram_we", bus.ram_write_en, 0);
    chk("rst_rd_addr", bus.ram_rd_addr, 0);
    rst = 1'b0;
    #1 chk("ram_en_run", bus.ram_en, 1);
    chk("idle_sel_ready", bus.sel_ready, 1);

    // State 3: tie at 40 resolves to lowest index.
    do_write(6'd12, 5); do_write(6'd13, -2); do_write(6'd14, 40); do_write(6'd15, 40);
    start_sel(4'd3);
    wait_done(1, 2, 40);

    // State 0: all negative, first entry wins.
    do_write(6'd0, -1); do_write(6'd1, -7); do_write(6'd2, -3); do_write(6'd3, -32768);
    start_sel(4'd0);
    wait_done(1, 0, -1);

    // State 1: write and request in the same IDLE cycle; write wins.
    do_write(6'd4, 10); do_write(6'd5, 20); do_write(6'd7, 30);
    @(negedge clk);
    bus.sel_req = 1'b1; bus.sel_state = 4'd1;
    bus.upd_valid = 1'b1; bus.upd_addr = 6'd6; bus.upd_data = 16'sd100;
    #1 chk("coll_upd_ready", bus.upd_ready, 1);
    chk("coll_sel_ready", bus.sel_ready, 0);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    #1 chk("coll_sel_ready_next", bus.sel_ready, 1);
    @(negedge clk);
    bus.sel_req = 1'b0;
    wait_done(1, 2, 100);

    // State 2: write to the scanned state is held off until IDLE.
    do_write(6'd8, 7); do_write(6'd9, 50); do_write(6'd10, -4); do_write(6'd11, 50);
    start_sel(4'd2);
    bus.upd_valid = 1'b1; bus.upd_addr = 6'd9; bus.upd_data = 16'sd1000;
    for (int c = 1; c <= 6; c++) begin
      #1 chk("blocked_upd_ready", bus.upd_ready, 0);
      if (c < 6) @(negedge clk);
    end
    chk("blk_sel_done", bus.sel_done, 1);
    chk("blk_sel_action", bus.sel_action, 1);
    chk("blk_sel_value", bus.sel_value, 50);
    @(negedge clk);
    #1 chk("unblocked_upd_ready", bus.upd_ready, 1);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    chk("blk_mem9", mem[9], 1000);

    // State 2 again: write to another state proceeds during the scan.
    start_sel(4'd2);
    bus.upd_valid = 1'b1; bus.upd_addr = 6'd40; bus.upd_data = 16'sd123;
    #1 chk("concurrent_upd_ready", bus.upd_ready, 1);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    wait_done(2, 1, 1000);
    chk("mem40", mem[40], 123);

    // Reset in the middle of a search.
    start_sel(4'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel_done", bus.sel_done, 0);
    chk("mid_rst_sel_action", bus.sel_action, 0);
    chk("mid_rst_sel_value", bus.sel_value, 0);
    chk("mid_rst_ram_en", bus.ram_en, 0);
    chk("mid_rst_rd_addr", bus.ram_rd_addr, 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.sel_done) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    start_sel(4'd3);
    wait_done(1, 2, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/action_select_ctrl.md
ACTION_SELECT_CTRL -- requirements
Module: action_select_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, action-value width, signed two's complement.
REQ-002 Parameter: ADDR_W, 6, action RAM address width; address = {state[3:0], action[1:0]}.
REQ-003 Parameter: N_ACT, 4, actions per state.
REQ-004 One clock; reset is synchronous and active-high. Ports clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 sel_req  in  1  request greedy action for sel_state.
REQ-008 sel_state  in  4  state index to search.
REQ-009 sel_ready  out  1  controller accepts sel_req this cycle.
REQ-010 sel_done  out  1  one-cycle pulse; result valid.
REQ-011 sel_action  out  2  argmax action index.
REQ-012 sel_value  out  DATA_W  maximum action value.
REQ-013 upd_valid  in  1  Q-update write request.
REQ-014 upd_addr  in  ADDR_W  write address.
REQ-015 upd_data  in  DATA_W  write data.
REQ-016 upd_ready  out  1  write accepted this cycle.
REQ-017 ram_en, ram_write_en  out  1 each  action RAM enable and write enable.
REQ-018 ram_wr_addr, ram_rd_addr  out  ADDR_W  action RAM addresses.
REQ-019 ram_data_in  out  DATA_W; ram_data_out  in  DATA_W  RAM read data, valid one cycle after ram_rd_addr.

Function
REQ-020 FSM states IDLE, SCAN, DRAIN, DONE.
REQ-021 IDLE: sel_ready=1 unless a write is accepted that cycle; sel_req&sel_ready at cycle T latches sel_state and enters SCAN.
REQ-022 SCAN: cycles T+1..T+4 drive ram_rd_addr={state,k}, k=0..3; then DRAIN for one cycle (T+5).
REQ-023 Data for action k is compared at T+2+k; running best updated only if strictly greater (signed), so ties resolve to lowest index.
REQ-024 First compare (k=0) loads best unconditionally.
REQ-025 DONE at T+6: sel_done=1 for exactly one cycle; return to IDLE at T+7; latency accept-to-done = 6 cycles.
REQ-026 sel_action/sel_value registered, update only at DONE, hold until next DONE.
REQ-027 Writes: upd_ready=1 and single-cycle write (ram_write_en=1, ram_wr_addr=upd_addr, ram_data_in=upd_data) when upd_valid and not blocked.
REQ-028 Blocked: FSM in SCAN/DRAIN/DONE and upd_addr[5:2]==latched state; upd_ready=0 until IDLE.
REQ-029 Writes to other states proceed concurrently with SCAN.
REQ-030 IDLE with sel_req and upd_valid same cycle: write wins, sel_ready=0; search accepted next cycle if sel_req still high.
REQ-031 sel_req outside IDLE ignored; requester must hold sel_req until sel_ready.
REQ-032 ram_en=1 in every cycle except while rst is high.

Reset
REQ-033 rst high at a clock edge: FSM->IDLE, sel_done=0, sel_action=0, sel_value=0, ram_en=0, ram_write_en=0, addresses and ram_data_in=0, scan counter and best registers cleared.
REQ-034 rst mid-search abandons the search; no sel_done issued; next request after rst low runs normally.

Structure
REQ-035 DATA_W, ADDR_W, N_ACT, state/action field widths and FSM state encoding live in shared package rl_pkg.
REQ-036 Running signed argmax (best value/index register, compare, load) is sub-module action_argmax.

Verification
REQ-037 Write addrs 12..15 = 5, -2, 40, 40; select state 3 -> sel_done at T+6, sel_action=2, sel_value=40.
REQ-038 State 0 = -1, -7, -3, -32768; select -> sel_action=0, sel_value=-1.
REQ-039 IDLE: sel_req state 1 with upd_valid addr 6 data 100 same cycle -> upd_ready=1, sel_ready=0; search accepted next cycle; result action 2, value 100.
REQ-040 During scan of state 2: upd_valid addr 9 -> upd_ready=0 until IDLE; upd_valid addr 40 -> accepted immediately, scan result unaffected.
REQ-041 rst at T+3 of a search -> next cycle all outputs 0, no sel_done; fresh request then completes in 6 cycles.
